// File: rtl/pulse_stretcher.sv
// -----------------------------------------------------------------------------
// pulse_stretcher
//
// Turns single-cycle event requests into fixed-length LED bursts. Each burst is
// ON_CYCLES high, followed by at least GAP_CYCLES forced low. Events that arrive
// while a burst or gap is in progress are queued, up to PEND_MAX of them. Events
// that arrive when the queue is full are dropped and flagged on overflow.
//
// Ports
//   clk       in   single clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   pulse_in  in   event request, one event per cycle sampled high
//   led_out   out  registered stretched output, high exactly in ON
//   busy      out  registered, high whenever the FSM is not IDLE
//   pending   out  registered count of queued events not yet started
//   overflow  out  registered one-cycle flag per dropped event
//
// States
//   state | meaning
//   IDLE  | no burst active, queue empty
//   ON    | led_out high, timer counts down the burst
//   GAP   | led_out forced low, timer counts down the separation
// -----------------------------------------------------------------------------
module pulse_stretcher #(
    parameter int ON_CYCLES  = 4,
    parameter int GAP_CYCLES = 2,
    parameter int PEND_MAX   = 3
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            pulse_in,
    output logic                            led_out,
    output logic                            busy,
    output logic [$clog2(PEND_MAX+1)-1:0]   pending,
    output logic                            overflow
);

    localparam int MAXC = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
    localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int PW   = $clog2(PEND_MAX + 1);

    localparam logic [TW-1:0] ON_LOAD   = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES - 1);
    localparam logic [PW-1:0] PEND_FULL = PW'(PEND_MAX);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [PW-1:0] pend_q,  pend_d;
    logic          ovf_d;
    logic          led_q;
    logic          busy_q;
    logic          ovf_q;
    logic          queue_ev;

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        pend_d   = pend_q;
        ovf_d    = 1'b0;
        queue_ev = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (pend_q != '0) begin
                    // Start from the queue; a coincident pulse refills the slot.
                    state_d = ST_ON;
                    timer_d = ON_LOAD;
                    if (!pulse_in) begin
                        pend_d = pend_q - PW'(1);
                    end
                end else if (pulse_in) begin
                    state_d = ST_ON;
                    timer_d = ON_LOAD;
                end
            end

            ST_ON: begin
                queue_ev = pulse_in;
                if (timer_q == '0) begin
                    state_d = ST_GAP;
                    timer_d = GAP_LOAD;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end

            ST_GAP: begin
                if (timer_q != '0) begin
                    queue_ev = pulse_in;
                    timer_d  = timer_q - TW'(1);
                end else if (pend_q != '0) begin
                    state_d = ST_ON;
                    timer_d = ON_LOAD;
                    if (!pulse_in) begin
                        pend_d = pend_q - PW'(1);
                    end
                end else if (pulse_in) begin
                    // Final gap cycle with an empty queue: start straight away.
                    state_d = ST_ON;
                    timer_d = ON_LOAD;
                end else begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase

        if (queue_ev) begin
            if (pend_q != PEND_FULL) begin
                pend_d = pend_q + PW'(1);
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            led_q   <= (state_d == ST_ON);
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    assign led_out  = led_q;
    assign busy     = busy_q;
    assign pending  = pend_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// -----------------------------------------------------------------------------
// tb_pulse_stretcher
//
// Directed bench for pulse_stretcher with default parameters. Each scenario is
// a pulse pattern plus hand-written per-cycle expectations held in strings:
// character k of an expectation string is the output value during cycle k,
// where cycle 0 is the cycle whose closing edge samples the first pattern bit.
// -----------------------------------------------------------------------------
module tb_pulse_stretcher;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       pulse_in = 1'b0;
    logic       led_out;
    logic       busy;
    logic       overflow;
    logic [1:0] pending;

    int checks = 0;
    int errors = 0;
    int led_hi = 0;

    always #5 clk = ~clk;

    pulse_stretcher #(
        .ON_CYCLES (4),
        .GAP_CYCLES(2),
        .PEND_MAX  (3)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .pulse_in(pulse_in),
        .led_out (led_out),
        .busy    (busy),
        .pending (pending),
        .overflow(overflow)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic p);
        pulse_in = p;
        @(posedge clk);
        #1;
        pulse_in = 1'b0;
    endtask

    task automatic do_reset();
        pulse_in = 1'b0;
        rst_n    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic scen(input string name, input string pin, input string led_e,
                        input string busy_e, input string pend_e, input string ovf_e,
                        output int hi);
        hi = 0;
        do_reset();
        for (int c = 1; c <= pin.len(); c++) begin
            tick(pin[c-1] == "1");
            if (led_out === 1'b1) hi++;
            chk($sformatf("%s c%0d led", name, c), 8'(led_out), 8'(led_e[c]) - 8'd48);
            chk($sformatf("%s c%0d busy", name, c), 8'(busy), 8'(busy_e[c]) - 8'd48);
            chk($sformatf("%s c%0d pending", name, c), 8'(pending), 8'(pend_e[c]) - 8'd48);
            chk($sformatf("%s c%0d overflow", name, c), 8'(overflow), 8'(ovf_e[c]) - 8'd48);
        end
    endtask

    initial begin
        // Reset state at power-up.
        #2;
        chk("por led", 8'(led_out), 8'd0);
        chk("por busy", 8'(busy), 8'd0);
        chk("por pending", 8'(pending), 8'd0);
        chk("por overflow", 8'(overflow), 8'd0);

        scen("single", "100000000",
             "-111100000", "-111111000", "-000000000", "-000000000", led_hi);
        chk("single led_total", 8'(led_hi), 8'd4);

        scen("b2b", "11000000000000",
             "-11110011110000", "-11111111111100",
             "-01111100000000", "-00000000000000", led_hi);
        chk("b2b led_total", 8'(led_hi), 8'd8);

        scen("ovf", {"11111", "00000000000000000000"},
             "-1111001111001111001111000",
             {"-", "111111111111", "111111111111", "0"},
             "-0123332222221111110000000",
             {"-00001", "00000000000000000000"}, led_hi);
        chk("ovf led_total", 8'(led_hi), 8'd16);

        scen("bypass", "1000001000000",
             "-1111001111000", "-1111111111110",
             "-0000000000000", "-0000000000000", led_hi);
        chk("bypass led_total", 8'(led_hi), 8'd8);

        scen("consume_arrive", {"1100001", "000000000000"},
             "-1111001111001111000",
             {"-", "111111111", "111111111", "0"},
             {"-0", "11111111111", "0000000"},
             {"-", "0000000000", "000000000"}, led_hi);
        chk("consume_arrive led_total", 8'(led_hi), 8'd12);

        // Reset in the middle of a burst with events queued.
        do_reset();
        tick(1'b1);
        tick(1'b1);
        tick(1'b1);
        chk("rst pre led", 8'(led_out), 8'd1);
        chk("rst pre pending", 8'(pending), 8'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst async led", 8'(led_out), 8'd0);
        chk("rst async busy", 8'(busy), 8'd0);
        chk("rst async pending", 8'(pending), 8'd0);
        chk("rst async overflow", 8'(overflow), 8'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst held led", 8'(led_out), 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick(1'b0);
            chk($sformatf("rst post c%0d led", c), 8'(led_out), 8'd0);
            chk($sformatf("rst post c%0d busy", c), 8'(busy), 8'd0);
        end

        // First edge after release samples pulse_in normally.
        rst_n = 1'b0;
        #3;
        @(negedge clk);
        rst_n    = 1'b1;
        pulse_in = 1'b1;
        @(posedge clk);
        #1;
        pulse_in = 1'b0;
        chk("release first edge led", 8'(led_out), 8'd1);
        chk("release first edge pending", 8'(pending), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pulse_stretcher.md
PULSE_STRETCHER -- requirements
Module: pulse_stretcher

Interface
REQ-001 SHALL have parameter ON_CYCLES, default 4: led_out high cycles per burst (legal >= 1).
REQ-002 SHALL have parameter GAP_CYCLES, default 2: forced low cycles after each burst (legal >= 1).
REQ-003 SHALL have parameter PEND_MAX, default 3: maximum queued events (legal 1..255).
REQ-004 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port pulse_in  input  1  event request; every cycle sampled high is one event; driven by a one-cycle pulse source.
REQ-007 SHALL have port led_out  output  1  registered stretched output.
REQ-008 SHALL have port busy  output  1  registered; high whenever state is not IDLE.
REQ-009 SHALL have port pending  output  $clog2(PEND_MAX+1)  registered count of queued events not yet started.
REQ-010 SHALL have port overflow  output  1  registered; one-cycle flag for each dropped event.

Function
REQ-011 SHALL implement states IDLE, ON, GAP with a down-counting timer wide enough for max(ON_CYCLES, GAP_CYCLES)-1.
REQ-012 SHALL set led_out = 1 exactly in state ON and 0 otherwise.
REQ-013 IDLE with pulse_in = 1 or pending > 0 SHALL go to ON with timer = ON_CYCLES-1. led_out is high in the cycle after the sampling edge, so latency is 1 cycle.
REQ-014 IDLE start SHALL use pulse_in directly and not increment pending when pending = 0. It SHALL consume one pending event when pending > 0. A simultaneous pulse_in in that case is queued, so net pending is unchanged.
REQ-015 ON SHALL decrement the timer each cycle. When timer = 0 it SHALL go to GAP with timer = GAP_CYCLES-1.
REQ-016 GAP SHALL decrement the timer each cycle. When timer = 0:
- pending > 0: go to ON, consume one pending event, and queue any simultaneous pulse_in.
- pending = 0 and pulse_in = 1: go to ON using pulse_in directly (bypass); pending stays 0.
- otherwise: go to IDLE.
REQ-017 pulse_in = 1 in ON, or in GAP with timer != 0, SHALL increment pending when pending < PEND_MAX.
REQ-018 An event arriving when pending = PEND_MAX and not consumed that cycle SHALL be dropped, with overflow = 1 in the following cycle only. pending SHALL never exceed PEND_MAX or wrap.
REQ-019 N accepted events SHALL produce exactly N bursts of ON_CYCLES high cycles, each separated by at least GAP_CYCLES low cycles. Bursts SHALL never merge or truncate.
REQ-020 pulse_in SHALL be the only input that affects behaviour. The block SHALL hold no combinational path from pulse_in to any output.

Reset
REQ-021 rst_n = 0 SHALL immediately force state IDLE, timer 0, led_out 0, busy 0, pending 0, overflow 0, independent of clk.
REQ-022 Reset asserted mid-burst or mid-gap SHALL discard the burst and all queued events. No burst resumes after release.
REQ-023 The first rising clk edge after rst_n deasserts SHALL sample pulse_in normally.

Verification
REQ-024 Scenario single pulse (defaults), pulse_in high 1 cycle in IDLE -> led_out high for cycles +1..+4, busy high for cycles +1..+6, pending stays 0, then IDLE.
REQ-025 Scenario back-to-back, pulses at cycles 0 and 1 -> pending = 1 at cycle 2; led_out pattern from cycle 1 is 1111 00 1111 00; pending = 0 from cycle 7.
REQ-026 Scenario overflow, pulses at cycles 0..4 -> pending reaches 3 at cycle 4; overflow = 1 only at cycle 5; exactly 4 bursts (16 led_out high cycles total).
REQ-027 Scenario bypass, second pulse on the final GAP cycle (cycle 6 after a pulse at cycle 0) -> led_out high for cycles 7..10, pending stays 0, no extra gap.
REQ-028 Scenario reset mid-operation, pulses at cycles 0..2 then rst_n low at cycle 3 for 2 cycles -> led_out, pending, busy = 0 asynchronously; no led_out activity after release without new pulses.
REQ-029 Scenario simultaneous consume and arrive, with pending = 1 and a pulse at the GAP-end cycle -> new burst starts and pending remains 1.
